nco_cfg_sequencer: RTL and testbench
====================================

NCO_CFG_SEQUENCER -- requirements
Module: nco_cfg_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65536: maximum cycles a staged update waits for phase_wrap before a forced commit.
REQ-002 Parameter DUTY_RESET, default 16'h8000: reset value of duty_cycle (50%).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_start  input  1  one-cycle pulse; I2C START plus address match, write direction.
REQ-006 rx_stop  input  1  one-cycle pulse; I2C STOP ends the transaction.
REQ-007 rx_valid  input  1  received byte available on rx_data.
REQ-008 rx_data  input  8  received byte.
REQ-009 rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high in the same cycle.
REQ-010 phase_wrap  input  1  one-cycle pulse from the NCO at phase-accumulator wrap.
REQ-011 enable  output  1  committed NCO enable.
REQ-012 wave  output  2  committed waveform select.
REQ-013 frequency  output  64  committed frequency tuning word.
REQ-014 duty_cycle  output  16  committed duty cycle.
REQ-015 commit  output  1  one-cycle pulse in the cycle after the outputs are updated.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  sticky protocol-error flag; cleared by the next accepted rx_start.

Function
REQ-018 States: IDLE, CTRL, FREQ, DUTY, DRAIN, PENDING, COMMIT.
REQ-019 IDLE: rx_start -> CTRL, clears err; bytes are accepted (rx_ready=1) and discarded.
REQ-020 CTRL: accepted byte goes to shadow control. Bit0=enable, bits2:1=wave, bit3=frequency follows, bit4=duty follows. Next state: FREQ if bit3, else DUTY if bit4, else DRAIN.
REQ-021 FREQ: accepts exactly 8 bytes, MSB first, into shadow frequency, then goes to DUTY if bit4 is set, else DRAIN.
REQ-022 DUTY: accepts exactly 2 bytes, MSB first, into shadow duty, then goes to DRAIN.
REQ-023 DRAIN: any further accepted byte sets err and is discarded; rx_stop -> PENDING if err=0, else IDLE.
REQ-024 rx_stop in CTRL, FREQ or DUTY (short transaction): sets err, discards the shadow registers, goes to IDLE; committed outputs stay unchanged.
REQ-025 rx_start while in CTRL, FREQ, DUTY or DRAIN (repeated start): sets err, discards the shadow registers, goes to CTRL.
REQ-026 PENDING: rx_ready=0. Go to COMMIT on phase_wrap, immediately if committed enable=0, or when the timeout counter reaches TIMEOUT_CYCLES-1.
REQ-027 COMMIT (one cycle): control is always copied. Frequency is copied only if control bit3=1; duty only if bit4=1. All copied fields update in the same edge. Next state IDLE. commit pulses the following cycle.
REQ-028 An rx_start arriving in PENDING or COMMIT is latched in one pending-start flag. On leaving COMMIT with the flag set, go directly to CTRL and clear the flag.
REQ-029 rx_ready=1 in IDLE, CTRL, FREQ, DUTY and DRAIN; rx_ready=0 in PENDING and COMMIT.
REQ-030 Byte counter is 4 bits and resets on every state entry. Timeout counter is 17 bits, cleared on PENDING entry, saturating.
REQ-031 Simultaneous rx_valid and rx_stop in the same cycle: the byte is accepted first, then the stop is evaluated with the updated count.
REQ-032 phase_wrap outside PENDING has no effect.

Reset
REQ-033 Reset clears state to IDLE, all counters, the shadow registers, err, commit, the pending-start flag and busy.
REQ-034 Reset output values: enable=0, wave=2'b00, frequency=64'h0, duty_cycle=DUTY_RESET.
REQ-035 Reset asserted mid-transaction or in PENDING abandons the update with no commit pulse.

Structure
REQ-036 A shared package nco_pkg holds the state enum, the control-bit index constants (EN=0, WAVE=2:1, FREQ_F=3, DUTY_F=4), and FREQ_BYTES=8 and DUTY_BYTES=2.
REQ-037 One sub-module, nco_cfg_shadow, holds the shadow registers and byte-assembly shifters; FSM, counters and commit logic stay in the top module.

Verification
REQ-038 Bytes 0x0B, 00 00 00 00 00 01 00 00, stop, committed enable=0 -> commit with no wait; outputs enable=1, wave=1, frequency=64'h10000; duty stays 16'h8000.
REQ-039 With enable=1, bytes 0x11, 0x40, 0x00, stop -> no change until phase_wrap. On the edge after phase_wrap, duty_cycle=16'h4000, enable=1, wave=0; commit is high the following cycle.
REQ-040 Bytes 0x08 plus 3 frequency bytes, then stop -> err=1, no commit, outputs unchanged.
REQ-041 A 4th byte after a complete 0x10 transaction -> err=1; the stop does not commit.
REQ-042 With enable=1, TIMEOUT_CYCLES=16 and no phase_wrap -> commit exactly 16 cycles after PENDING entry.
REQ-043 rx_start during PENDING followed by phase_wrap -> commit, then CTRL without passing through IDLE; err remains 0.

Source files
------------

// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
// Shared definitions for the NCO configuration sequencer:
//   - state_e        : sequencer FSM states
//   - control-byte bit indices (EN, WAVE_HI:WAVE_LO, FREQ_F, DUTY_F)
//   - FREQ_BYTES / DUTY_BYTES : payload lengths of the optional fields
//   - after_ctrl()   : picks the next payload state from the field flags
// -----------------------------------------------------------------------------
package nco_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CTRL    = 3'd1,
        ST_FREQ    = 3'd2,
        ST_DUTY    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_PENDING = 3'd5,
        ST_COMMIT  = 3'd6
    } state_e;

    // Control byte layout
    localparam int EN      = 0;
    localparam int WAVE_LO = 1;
    localparam int WAVE_HI = 2;
    localparam int FREQ_F  = 3;
    localparam int DUTY_F  = 4;
    localparam int CTRL_W  = 5;   // bits 7:5 of the control byte are ignored

    localparam int FREQ_BYTES = 8;
    localparam int DUTY_BYTES = 2;

    // Next payload state once the control byte (or the frequency field) is done.
    function automatic state_e after_ctrl(input logic freq_f, input logic duty_f);
        if (freq_f) begin
            return ST_FREQ;
        end
        if (duty_f) begin
            return ST_DUTY;
        end
        return ST_DRAIN;
    endfunction

endpackage

// File: rtl/nco_cfg_shadow.sv
// -----------------------------------------------------------------------------
// nco_cfg_shadow
// Shadow copy of an in-flight configuration: control bits plus the MSB-first
// byte-assembly shifters for the frequency word and the duty cycle.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   clear_i           : drop the whole shadow (aborted/restarted transaction)
//   ctrl_we_i         : load control bits from byte_i
//   freq_shift_i      : shift byte_i into the frequency word (MSB first)
//   duty_shift_i      : shift byte_i into the duty cycle (MSB first)
//   byte_i            : received byte
//   ctrl_o/freq_o/duty_o : shadow contents
// -----------------------------------------------------------------------------
module nco_cfg_shadow
    import nco_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              ctrl_we_i,
    input  logic              freq_shift_i,
    input  logic              duty_shift_i,
    input  logic [7:0]        byte_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [63:0]       freq_o,
    output logic [15:0]       duty_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [63:0]       freq_q;
    logic [15:0]       duty_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            freq_q <= '0;
            duty_q <= '0;
        end else if (clear_i) begin
            ctrl_q <= '0;
            freq_q <= '0;
            duty_q <= '0;
        end else begin
            if (ctrl_we_i) begin
                ctrl_q <= byte_i[CTRL_W-1:0];
            end
            if (freq_shift_i) begin
                freq_q <= {freq_q[55:0], byte_i};
            end
            if (duty_shift_i) begin
                duty_q <= {duty_q[7:0], byte_i};
            end
        end
    end

    assign ctrl_o = ctrl_q;
    assign freq_o = freq_q;
    assign duty_o = duty_q;

endmodule

// File: rtl/nco_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// nco_cfg_sequencer
// Receives an I2C write transaction (control byte, optional 8-byte frequency,
// optional 2-byte duty), stages it in nco_cfg_shadow and commits it to the NCO
// outputs on phase_wrap, immediately when the NCO is disabled, or on timeout.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rx_start/rx_stop      : I2C START(+addr match, write) / STOP pulses
//   rx_valid/rx_data      : received byte, accepted when rx_ready is high
//   rx_ready              : low only while an update is pending/committing
//   phase_wrap            : NCO phase-accumulator wrap pulse
//   enable/wave/frequency/duty_cycle : committed NCO configuration
//   commit                : one-cycle pulse after the outputs changed
//   busy                  : FSM not in IDLE
//   err                   : sticky protocol error, cleared by the next START
// -----------------------------------------------------------------------------
module nco_cfg_sequencer
    import nco_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 65536,
    parameter logic [15:0] DUTY_RESET     = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_start,
    input  logic        rx_stop,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        phase_wrap,
    output logic        enable,
    output logic [1:0]  wave,
    output logic [63:0] frequency,
    output logic [15:0] duty_cycle,
    output logic        commit,
    output logic        busy,
    output logic        err
);

    localparam logic [16:0] TO_LAST   = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  FREQ_LAST = 4'(FREQ_BYTES - 1);
    localparam logic [3:0]  DUTY_LAST = 4'(DUTY_BYTES - 1);

    state_e      state_q, state_d, eff_state;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [16:0] to_cnt_q, to_cnt_d;
    logic        err_q, err_d;
    logic        start_pend_q, start_pend_d;
    logic        commit_q;
    logic        enable_q;
    logic [1:0]  wave_q;
    logic [63:0] freq_q;
    logic [15:0] duty_q;

    logic        accept;
    logic        restart;
    logic        do_commit;
    logic        shadow_clear, ctrl_we, freq_shift, duty_shift;

    logic [CTRL_W-1:0] sh_ctrl;
    logic [63:0]       sh_freq;
    logic [15:0]       sh_duty;

    assign rx_ready = (state_q != ST_PENDING) && (state_q != ST_COMMIT);
    assign accept   = rx_valid && rx_ready;

    nco_cfg_shadow u_shadow (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (shadow_clear),
        .ctrl_we_i    (ctrl_we),
        .freq_shift_i (freq_shift),
        .duty_shift_i (duty_shift),
        .byte_i       (rx_data),
        .ctrl_o       (sh_ctrl),
        .freq_o       (sh_freq),
        .duty_o       (sh_duty)
    );

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        eff_state    = state_q;
        err_d        = err_q;
        start_pend_d = start_pend_q;
        restart      = 1'b0;
        do_commit    = 1'b0;
        shadow_clear = 1'b0;
        ctrl_we      = 1'b0;
        freq_shift   = 1'b0;
        duty_shift   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Bytes outside a transaction are accepted and dropped.
                if (rx_start) begin
                    state_d      = ST_CTRL;
                    err_d        = 1'b0;
                    shadow_clear = 1'b1;
                end
            end

            ST_CTRL, ST_FREQ, ST_DUTY, ST_DRAIN: begin
                if (rx_start) begin
                    // Repeated START: abandon what was staged and restart.
                    state_d      = ST_CTRL;
                    err_d        = 1'b1;
                    shadow_clear = 1'b1;
                    restart      = 1'b1;
                end else begin
                    // First account for a byte in this cycle, then judge a
                    // STOP against the state the byte leaves us in.
                    if (accept) begin
                        case (state_q)
                            ST_CTRL: begin
                                ctrl_we   = 1'b1;
                                eff_state = after_ctrl(rx_data[FREQ_F], rx_data[DUTY_F]);
                            end
                            ST_FREQ: begin
                                freq_shift = 1'b1;
                                if (byte_cnt_q == FREQ_LAST) begin
                                    eff_state = after_ctrl(1'b0, sh_ctrl[DUTY_F]);
                                end
                            end
                            ST_DUTY: begin
                                duty_shift = 1'b1;
                                if (byte_cnt_q == DUTY_LAST) begin
                                    eff_state = ST_DRAIN;
                                end
                            end
                            default: begin
                                err_d = 1'b1;   // surplus byte in DRAIN
                            end
                        endcase
                    end
                    state_d = eff_state;
                    if (rx_stop) begin
                        if (eff_state == ST_DRAIN) begin
                            state_d = err_d ? ST_IDLE : ST_PENDING;
                        end else begin
                            state_d      = ST_IDLE;
                            err_d        = 1'b1;
                            shadow_clear = 1'b1;
                        end
                    end
                end
            end

            ST_PENDING: begin
                if (rx_start) begin
                    start_pend_d = 1'b1;
                end
                if (phase_wrap || !enable_q || (to_cnt_q == TO_LAST)) begin
                    state_d   = ST_COMMIT;
                    do_commit = 1'b1;
                end
            end

            ST_COMMIT: begin
                if (start_pend_q || rx_start) begin
                    state_d      = ST_CTRL;
                    start_pend_d = 1'b0;
                    err_d        = 1'b0;
                    shadow_clear = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte counter restarts on every state entry, including a repeated START.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if ((state_d != state_q) || restart) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + 4'd1;
        end
    end

    // Held at zero outside PENDING, so it starts from zero on entry; saturates.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != ST_PENDING) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + 17'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
            start_pend_q <= start_pend_d;
        end
    end

    // Committed configuration: all selected fields change on one edge and the
    // commit pulse is visible in the cycle that follows it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
            wave_q   <= 2'b00;
            freq_q   <= '0;
            duty_q   <= DUTY_RESET;
            commit_q <= 1'b0;
        end else begin
            commit_q <= do_commit;
            if (do_commit) begin
                enable_q <= sh_ctrl[EN];
                wave_q   <= sh_ctrl[WAVE_HI:WAVE_LO];
                if (sh_ctrl[FREQ_F]) begin
                    freq_q <= sh_freq;
                end
                if (sh_ctrl[DUTY_F]) begin
                    duty_q <= sh_duty;
                end
            end
        end
    end

    assign enable     = enable_q;
    assign wave       = wave_q;
    assign frequency  = freq_q;
    assign duty_cycle = duty_q;
    assign commit     = commit_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_nco_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nco_cfg_sequencer
// Self-checking bench: each scenario task drives I2C-style byte traffic and
// checks inline; predicted committed configurations are queued when a
// committing transaction is driven and compared when commit pulses.
// -----------------------------------------------------------------------------
module tb_nco_cfg_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_start, rx_stop, rx_valid, phase_wrap;
    logic [7:0]  rx_data;
    logic        rx_ready, enable, commit, busy, err;
    logic [1:0]  wave;
    logic [63:0] frequency;
    logic [15:0] duty_cycle;

    typedef struct {
        logic        en;
        logic [1:0]  wave;
        logic [63:0] freq;
        logic [15:0] duty;
    } snap_t;

    snap_t exp_q[$];
    snap_t model;
    int    n_pass     = 0;
    int    n_total    = 0;
    int    commit_cnt = 0;

    always #5 clk = ~clk;

    nco_cfg_sequencer #(
        .TIMEOUT_CYCLES (16),
        .DUTY_RESET     (16'h8000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_start   (rx_start),
        .rx_stop    (rx_stop),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .phase_wrap (phase_wrap),
        .enable     (enable),
        .wave       (wave),
        .frequency  (frequency),
        .duty_cycle (duty_cycle),
        .commit     (commit),
        .busy       (busy),
        .err        (err)
    );

    // Scoreboard side: every commit pulse must match the oldest prediction.
    always @(negedge clk) begin : sb_monitor
        snap_t e;
        if (!reset && commit === 1'b1) begin
            commit_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected_commit got en=%0b wave=%0d freq=%h duty=%h",
                         enable, wave, frequency, duty_cycle);
            end else begin
                e = exp_q.pop_front();
                n_total++;
                if (enable !== e.en) $display("FAIL sb_enable got=%0b exp=%0b", enable, e.en);
                else n_pass++;
                n_total++;
                if (wave !== e.wave) $display("FAIL sb_wave got=%0d exp=%0d", wave, e.wave);
                else n_pass++;
                n_total++;
                if (frequency !== e.freq) $display("FAIL sb_freq got=%h exp=%h", frequency, e.freq);
                else n_pass++;
                n_total++;
                if (duty_cycle !== e.duty) $display("FAIL sb_duty got=%h exp=%h", duty_cycle, e.duty);
                else n_pass++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_start();
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
    endtask

    task automatic send_stop();
        rx_stop = 1'b1;
        tick();
        rx_stop = 1'b0;
    endtask

    task automatic pulse_wrap();
        phase_wrap = 1'b1;
        tick();
        phase_wrap = 1'b0;
    endtask

    // Predict the committed configuration after a transaction with this control byte.
    task automatic expect_commit(input logic [7:0] ctrl, input logic [63:0] f,
                                 input logic [15:0] d);
        model.en   = ctrl[0];
        model.wave = ctrl[2:1];
        if (ctrl[3]) model.freq = f;
        if (ctrl[4]) model.duty = d;
        exp_q.push_back(model);
    endtask

    task automatic model_reset();
        model.en   = 1'b0;
        model.wave = 2'b00;
        model.freq = 64'h0;
        model.duty = 16'h8000;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_total++; if (enable !== 1'b0) $display("FAIL rst_enable got=%0b exp=0", enable); else n_pass++;
        n_total++; if (wave !== 2'b00) $display("FAIL rst_wave got=%0d exp=0", wave); else n_pass++;
        n_total++; if (frequency !== 64'h0) $display("FAIL rst_freq got=%h exp=0", frequency); else n_pass++;
        n_total++; if (duty_cycle !== 16'h8000) $display("FAIL rst_duty got=%h exp=8000", duty_cycle); else n_pass++;
        n_total++; if (commit !== 1'b0) $display("FAIL rst_commit got=%0b exp=0", commit); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rst_err got=%0b exp=0", err); else n_pass++;
        n_total++; if (rx_ready !== 1'b1) $display("FAIL rst_rx_ready got=%0b exp=1", rx_ready); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_immediate_commit();
        logic [7:0] fb [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        int c0 = commit_cnt;
        send_start();
        send_byte(8'h0B);
        foreach (fb[i]) send_byte(fb[i]);
        expect_commit(8'h0B, 64'h10000, 16'h0);
        send_stop();
        n_total++; if (rx_ready !== 1'b0) $display("FAIL imm_pending_ready got=%0b exp=0", rx_ready); else n_pass++;
        tick();
        n_total++; if (commit !== 1'b1) $display("FAIL imm_commit got=%0b exp=1", commit); else n_pass++;
        n_total++; if (frequency !== 64'h10000) $display("FAIL imm_freq got=%h exp=10000", frequency); else n_pass++;
        tick();
        n_total++; if (commit !== 1'b0) $display("FAIL imm_commit_width got=%0b exp=0", commit); else n_pass++;
        n_total++; if (commit_cnt !== c0 + 1) $display("FAIL imm_count got=%0d exp=%0d", commit_cnt, c0 + 1); else n_pass++;
    endtask

    task automatic test_phase_wrap();
        int c0 = commit_cnt;
        send_start();
        send_byte(8'h11);
        send_byte(8'h40);
        send_byte(8'h00);
        expect_commit(8'h11, 64'h0, 16'h4000);
        send_stop();
        repeat (5) tick();
        n_total++; if (duty_cycle !== 16'h8000) $display("FAIL wrap_hold_duty got=%h exp=8000", duty_cycle); else n_pass++;
        n_total++; if (commit_cnt !== c0) $display("FAIL wrap_early_commit got=%0d exp=%0d", commit_cnt, c0); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL wrap_busy got=%0b exp=1", busy); else n_pass++;
        pulse_wrap();
        n_total++; if (duty_cycle !== 16'h4000) $display("FAIL wrap_duty got=%h exp=4000", duty_cycle); else n_pass++;
        n_total++; if (enable !== 1'b1) $display("FAIL wrap_enable got=%0b exp=1", enable); else n_pass++;
        n_total++; if (wave !== 2'd0) $display("FAIL wrap_wave got=%0d exp=0", wave); else n_pass++;
        n_total++; if (commit !== 1'b1) $display("FAIL wrap_commit got=%0b exp=1", commit); else n_pass++;
        tick();
        n_total++; if (commit !== 1'b0) $display("FAIL wrap_commit_width got=%0b exp=0", commit); else n_pass++;
    endtask

    task automatic test_timeout();
        int n = 0;
        send_start();
        send_byte(8'h03);
        expect_commit(8'h03, 64'h0, 16'h0);
        send_stop();
        while (n < 40 && commit !== 1'b1) begin
            tick();
            n++;
        end
        n_total++; if (n !== 16) $display("FAIL timeout_cycles got=%0d exp=16", n); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int c0 = commit_cnt;
        send_start();
        send_byte(8'h01);
        expect_commit(8'h01, 64'h0, 16'h0);
        send_stop();
        send_start();            // lands in PENDING
        pulse_wrap();
        n_total++; if (commit !== 1'b1) $display("FAIL b2b_commit got=%0b exp=1", commit); else n_pass++;
        tick();
        n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy got=%0b exp=1", busy); else n_pass++;
        n_total++; if (rx_ready !== 1'b1) $display("FAIL b2b_ready got=%0b exp=1", rx_ready); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL b2b_err got=%0b exp=0", err); else n_pass++;
        send_byte(8'h05);
        expect_commit(8'h05, 64'h0, 16'h0);
        send_stop();
        pulse_wrap();
        n_total++; if (wave !== 2'd2) $display("FAIL b2b_wave got=%0d exp=2", wave); else n_pass++;
        tick();
        n_total++; if (commit_cnt !== c0 + 2) $display("FAIL b2b_count got=%0d exp=%0d", commit_cnt, c0 + 2); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_idle got=%0b exp=0", busy); else n_pass++;
    endtask

    task automatic test_short_txn();
        int c0 = commit_cnt;
        send_start();
        send_byte(8'h08);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_stop();
        n_total++; if (err !== 1'b1) $display("FAIL short_err got=%0b exp=1", err); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL short_busy got=%0b exp=0", busy); else n_pass++;
        pulse_wrap();            // no effect outside PENDING
        tick();
        n_total++; if (commit_cnt !== c0) $display("FAIL short_commit got=%0d exp=%0d", commit_cnt, c0); else n_pass++;
        n_total++; if (frequency !== model.freq) $display("FAIL short_freq got=%h exp=%h", frequency, model.freq); else n_pass++;
        n_total++; if (enable !== model.en) $display("FAIL short_enable got=%0b exp=%0b", enable, model.en); else n_pass++;
    endtask

    task automatic test_extra_byte();
        int c0 = commit_cnt;
        send_start();
        n_total++; if (err !== 1'b0) $display("FAIL extra_err_clear got=%0b exp=0", err); else n_pass++;
        send_byte(8'h10);
        send_byte(8'h12);
        send_byte(8'h34);
        n_total++; if (err !== 1'b0) $display("FAIL extra_err_early got=%0b exp=0", err); else n_pass++;
        send_byte(8'h56);
        n_total++; if (err !== 1'b1) $display("FAIL extra_err got=%0b exp=1", err); else n_pass++;
        send_stop();
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL extra_busy got=%0b exp=0", busy); else n_pass++;
        n_total++; if (commit_cnt !== c0) $display("FAIL extra_commit got=%0d exp=%0d", commit_cnt, c0); else n_pass++;
        n_total++; if (duty_cycle !== model.duty) $display("FAIL extra_duty got=%h exp=%h", duty_cycle, model.duty); else n_pass++;
    endtask

    task automatic test_repeated_start();
        int c0 = commit_cnt;
        send_start();
        send_byte(8'h08);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_start();
        n_total++; if (err !== 1'b1) $display("FAIL rstart_err got=%0b exp=1", err); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL rstart_busy got=%0b exp=1", busy); else n_pass++;
        send_byte(8'h01);
        send_stop();
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL rstart_idle got=%0b exp=0", busy); else n_pass++;
        n_total++; if (commit_cnt !== c0) $display("FAIL rstart_commit got=%0d exp=%0d", commit_cnt, c0); else n_pass++;
    endtask

    task automatic test_stop_with_byte();
        send_start();
        send_byte(8'h10);
        send_byte(8'hAB);
        expect_commit(8'h10, 64'h0, 16'hABCD);
        rx_valid = 1'b1;
        rx_data  = 8'hCD;
        rx_stop  = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_stop  = 1'b0;
        n_total++; if (rx_ready !== 1'b0) $display("FAIL swb_pending got=%0b exp=0", rx_ready); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL swb_err got=%0b exp=0", err); else n_pass++;
        pulse_wrap();
        n_total++; if (duty_cycle !== 16'hABCD) $display("FAIL swb_duty got=%h exp=abcd", duty_cycle); else n_pass++;
        tick();
    endtask

    task automatic test_reset_midway();
        int c0 = commit_cnt;
        send_start();
        send_byte(8'h0B);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 reset = 1'b1;
        #1;
        n_total++; if (frequency !== 64'h0) $display("FAIL mid_rst_freq got=%h exp=0", frequency); else n_pass++;
        n_total++; if (duty_cycle !== 16'h8000) $display("FAIL mid_rst_duty got=%h exp=8000", duty_cycle); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%0b exp=0", busy); else n_pass++;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        n_total++; if (commit_cnt !== c0) $display("FAIL mid_rst_commit got=%0d exp=%0d", commit_cnt, c0); else n_pass++;
        n_total++; if (enable !== 1'b0) $display("FAIL mid_rst_enable got=%0b exp=0", enable); else n_pass++;
    endtask

    initial begin
        reset      = 1'b1;
        rx_start   = 1'b0;
        rx_stop    = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        phase_wrap = 1'b0;
        model_reset();

        test_reset();
        test_immediate_commit();
        test_phase_wrap();
        test_timeout();
        test_back_to_back();
        test_short_txn();
        test_extra_byte();
        test_repeated_start();
        test_stop_with_byte();
        test_reset_midway();

        n_total++;
        if (exp_q.size() != 0) $display("FAIL sb_drain got=%0d exp=0 outstanding", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
